// File: rtl/jtframe_lfbuf_arb.sv
// Line-frame buffer arbiter: serialises whole-line read and write bursts onto a
// single-port memory with a registered read port, one burst at a time.
module jtframe_lfbuf_arb #(
    parameter  int VW = 8,
    parameter  int HW = 9,
    localparam int AW = HW + VW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame,

    input  logic          rd_req,
    input  logic [VW-1:0] rd_line,
    output logic [HW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    output logic          rd_we,
    output logic          rd_done,

    input  logic          wr_req,
    input  logic [VW-1:0] wr_line,
    output logic [HW-1:0] wr_addr,
    input  logic [15:0]   wr_din,
    output logic          wr_done,

    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic          mem_we,
    input  logic [15:0]   mem_dout,

    output logic          busy,
    output logic          ovr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [HW-1:0] CNT_ONE = HW'(1);

    state_t          state_q, state_d;
    logic [HW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   prev_q, prev_d;
    logic            drain_q, drain_d;
    logic            bank_q, bank_d;
    logic [VW-1:0]   line_q, line_d;
    logic            rd_we_q, rd_we_d;
    logic            rd_done_q, rd_done_d;
    logic            mem_we_q, mem_we_d;
    logic            wr_done_q, wr_done_d;
    logic            ovr_q, ovr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            prev_q    <= '0;
            drain_q   <= 1'b0;
            bank_q    <= 1'b0;
            line_q    <= '0;
            rd_we_q   <= 1'b0;
            rd_done_q <= 1'b0;
            mem_we_q  <= 1'b0;
            wr_done_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            drain_q   <= drain_d;
            bank_q    <= bank_d;
            line_q    <= line_d;
            rd_we_q   <= rd_we_d;
            rd_done_q <= rd_done_d;
            mem_we_q  <= mem_we_d;
            wr_done_q <= wr_done_d;
            ovr_q     <= ovr_d;
        end
    end

    // Both bursts issue 2**HW addresses then spend one drain cycle on the
    // delayed half (returned read word or pending memory write).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        drain_d   = drain_q;
        bank_d    = bank_q;
        line_d    = line_q;
        rd_we_d   = 1'b0;
        rd_done_d = 1'b0;
        mem_we_d  = 1'b0;
        wr_done_d = 1'b0;
        ovr_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                drain_d = 1'b0;
                if (rd_req) begin
                    state_d = ST_READ;
                    bank_d  = ~frame;
                    line_d  = rd_line;
                    ovr_d   = wr_req;
                end else if (wr_req) begin
                    state_d = ST_WRITE;
                    bank_d  = frame;
                    line_d  = wr_line;
                end
            end
            ST_READ, ST_WRITE: begin
                if (drain_q) begin
                    state_d   = ST_IDLE;
                    drain_d   = 1'b0;
                    rd_done_d = (state_q == ST_READ);
                    wr_done_d = (state_q == ST_WRITE);
                end else begin
                    prev_d   = cnt_q;
                    rd_we_d  = (state_q == ST_READ);
                    mem_we_d = (state_q == ST_WRITE);
                    if (cnt_q == '1) begin
                        drain_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic rd_issue;
    logic wr_issue;

    assign rd_issue = (state_q == ST_READ)  && !drain_q;
    assign wr_issue = (state_q == ST_WRITE) && !drain_q;

    always_comb begin
        mem_addr = '0;
        if (rd_issue) begin
            mem_addr = {bank_q, line_q, cnt_q};
        end else if (mem_we_q) begin
            mem_addr = {bank_q, line_q, prev_q};
        end
    end

    assign mem_we  = mem_we_q;
    assign mem_din = mem_we_q ? wr_din : '0;
    assign wr_addr = wr_issue ? cnt_q : '0;
    assign wr_done = wr_done_q;

    assign rd_we   = rd_we_q;
    assign rd_addr = rd_we_q ? prev_q : '0;
    assign rd_data = rd_we_q ? mem_dout : '0;
    assign rd_done = rd_done_q;

    assign busy = (state_q != ST_IDLE);
    assign ovr  = ovr_q;

endmodule

// File: tb/tb_jtframe_lfbuf_arb.sv
// Self-checking bench for jtframe_lfbuf_arb: burst-offset reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_jtframe_lfbuf_arb;

    localparam int VW = 8;
    localparam int HW = 9;
    localparam int AW = HW + VW + 1;
    localparam int N  = 1 << HW;

    localparam int K_IDLE  = 0;
    localparam int K_READ  = 1;
    localparam int K_WRITE = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame;
    logic          rd_req;
    logic [VW-1:0] rd_line;
    logic [HW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic          rd_we;
    logic          rd_done;
    logic          wr_req;
    logic [VW-1:0] wr_line;
    logic [HW-1:0] wr_addr;
    logic [15:0]   wr_din;
    logic          wr_done;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic          mem_we;
    logic [15:0]   mem_dout;
    logic          busy;
    logic          ovr;

    jtframe_lfbuf_arb #(.VW(VW), .HW(HW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .frame    (frame),
        .rd_req   (rd_req),
        .rd_line  (rd_line),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_we    (rd_we),
        .rd_done  (rd_done),
        .wr_req   (wr_req),
        .wr_line  (wr_line),
        .wr_addr  (wr_addr),
        .wr_din   (wr_din),
        .wr_done  (wr_done),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout),
        .busy     (busy),
        .ovr      (ovr)
    );

    always #5 clk = ~clk;

    // Environment memory (driven by the DUT) and the model's view of it
    logic [15:0] env_mem   [0:(1<<AW)-1];
    logic [15:0] model_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr] <= mem_din;
        mem_dout <= env_mem[mem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: burst kind, offset n within the burst, latched bank/line
    int            m_kind = K_IDLE;
    int            m_n = 0;
    logic          m_bank = 1'b0;
    logic [VW-1:0] m_line = '0;
    bit            m_rdone = 0;
    bit            m_wdone = 0;
    bit            m_ovr = 0;
    bit            pend_we = 0;
    logic [AW-1:0] pend_addr;
    logic [15:0]   pend_data;
    logic [15:0]   w_seed = '0;

    function automatic logic [AW-1:0] maddr(input int off);
        logic [HW-1:0] o;
        o = off[HW-1:0];
        return {m_bank, m_line, o};
    endfunction

    task automatic model_advance();
        if (pend_we) model_mem[pend_addr] = pend_data;
        pend_we = 0;
        m_rdone = 0;
        m_wdone = 0;
        if (m_kind == K_IDLE) begin
            m_n = 0;
            if (rd_req) begin
                m_kind = K_READ;  m_bank = ~frame; m_line = rd_line; m_ovr = wr_req;
            end else if (wr_req) begin
                m_kind = K_WRITE; m_bank = frame;  m_line = wr_line; m_ovr = 0;
            end
        end else if (m_n == N) begin
            m_rdone = (m_kind == K_READ);
            m_wdone = (m_kind == K_WRITE);
            m_kind  = K_IDLE;
        end else begin
            m_n++;
        end
    endtask

    task automatic check_cycle();
        logic          e_busy, e_rd_we, e_mem_we, e_ovr;
        logic [AW-1:0] e_addr;
        logic [15:0]   e_data;
        e_busy   = (m_kind != K_IDLE);
        e_rd_we  = (m_kind == K_READ)  && (m_n >= 1);
        e_mem_we = (m_kind == K_WRITE) && (m_n >= 1);
        e_ovr    = (m_kind == K_READ)  && (m_n == 0) && m_ovr;
        chk("busy", busy, e_busy);
        chk("rd_we", rd_we, e_rd_we);
        chk("mem_we", mem_we, e_mem_we);
        chk("ovr", ovr, e_ovr);
        chk("rd_done", rd_done, m_rdone);
        chk("wr_done", wr_done, m_wdone);
        if (m_kind == K_READ && m_n < N) chk("rd_mem_addr", mem_addr, maddr(m_n));
        if (m_kind == K_WRITE && m_n < N) chk("wr_addr", wr_addr, m_n);
        if (e_rd_we) begin
            e_addr = maddr(m_n - 1);
            chk("rd_addr", rd_addr, m_n - 1);
            chk("rd_data", rd_data, model_mem[e_addr]);
        end
        if (e_mem_we) begin
            e_addr = maddr(m_n - 1);
            e_data = 16'(m_n) + w_seed;
            chk("wr_mem_addr", mem_addr, e_addr);
            chk("mem_din", mem_din, e_data);
            pend_we = 1; pend_addr = e_addr; pend_data = e_data;
        end
    endtask

    // Producer and per-burst statistics
    logic [HW-1:0] last_wa = '0;
    bit            rand_mode = 0;
    int            rd_we_cnt, mem_we_cnt, wr_done_cnt;
    bit            first_set;
    logic [AW-1:0] first_ma, last_ma;
    logic [15:0]   first_md, last_md;

    task automatic random_drive();
        if (!rd_done && !rd_req && $urandom_range(0, 15) == 0) begin
            rd_req = 1'b1; rd_line = VW'($urandom);
        end else if (rd_req && $urandom_range(0, 299) == 0) begin
            rd_req = 1'b0;
        end
        if (!wr_done && !wr_req && $urandom_range(0, 15) == 0) begin
            wr_req = 1'b1; wr_line = VW'($urandom);
        end else if (wr_req && $urandom_range(0, 299) == 0) begin
            wr_req = 1'b0;
        end
        if ($urandom_range(0, 63) == 0) frame = ~frame;
        if ($urandom_range(0, 31) == 0) rd_line = VW'($urandom);
        if ($urandom_range(0, 31) == 0) wr_line = VW'($urandom);
    endtask

    task automatic step();
        logic [HW-1:0] wa;
        model_advance();
        @(posedge clk);
        #1;
        wa      = wr_addr;
        wr_din  = 16'(last_wa) + 16'd1 + w_seed;
        last_wa = wa;
        #1;
        check_cycle();
        if (rd_we) rd_we_cnt++;
        if (wr_done) wr_done_cnt++;
        if (mem_we) begin
            if (!first_set) begin first_ma = mem_addr; first_md = mem_din; first_set = 1; end
            last_ma = mem_addr; last_md = mem_din;
            mem_we_cnt++;
        end
        if (rd_done) rd_req = 1'b0;
        if (wr_done) wr_req = 1'b0;
        if (rand_mode) random_drive();
    endtask

    task automatic clear_stats();
        rd_we_cnt = 0; mem_we_cnt = 0; wr_done_cnt = 0; first_set = 0;
    endtask

    task automatic wait_done(input bit rd, output int cycles);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(rd ? rd_done : wr_done) && k < 700);
        chk(rd ? "rd_done_timeout" : "wr_done_timeout", (k < 700), 1);
        cycles = k;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < (1 << AW); i++) begin
            env_mem[i]   = 16'($urandom);
            model_mem[i] = env_mem[i];
        end
        rst_n = 1'b0; frame = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        rd_line = '0; wr_line = '0; wr_din = '0;
        clear_stats();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rd_we", rd_we, 0);
        rst_n = 1'b1;
        step();

        // Read line 0x12 with frame=0 -> bank 1
        frame = 1'b0; rd_line = 8'h12; rd_req = 1'b1; clear_stats();
        step();
        chk("A_first_addr", mem_addr, 18'h22400);
        chk("A_busy", busy, 1);
        wait_done(1, k);
        chk("A_done_cycle", 1 + k, 514);
        chk("A_rd_we_cnt", rd_we_cnt, 512);
        step(); step();

        // Write line 0x05 with frame=1, data = address+1
        frame = 1'b1; wr_line = 8'h05; w_seed = '0; wr_req = 1'b1; clear_stats();
        wait_done(0, k);
        repeat (3) step();
        chk("B_mem_we_cnt", mem_we_cnt, 512);
        chk("B_first_addr", first_ma, 18'h20A00);
        chk("B_first_data", first_md, 16'h0001);
        chk("B_last_addr", last_ma, 18'h20BFF);
        chk("B_last_data", last_md, 16'h0200);
        chk("B_wr_done_cnt", wr_done_cnt, 1);

        // Same-cycle requests: read wins with overrun, write after one idle cycle
        frame = 1'b0; rd_line = 8'h40; wr_line = 8'h41; rd_req = 1'b1; wr_req = 1'b1;
        step();
        chk("C_ovr", ovr, 1);
        wait_done(1, k);
        step();
        chk("C_write_busy", busy, 1);
        chk("C_write_addr0", wr_addr, 0);
        wait_done(0, k);
        step();

        // Read request withdrawn after 10 cycles
        rd_line = 8'h07; rd_req = 1'b1; clear_stats();
        repeat (10) step();
        rd_req = 1'b0;
        wait_done(1, k);
        chk("D_rd_we_cnt", rd_we_cnt, 512);
        step();

        // Frame and line change mid-write
        frame = 1'b0; wr_line = 8'h33; w_seed = 16'h1234; wr_req = 1'b1; clear_stats();
        repeat (100) step();
        frame = 1'b1; wr_line = 8'h34;
        wait_done(0, k);
        chk("E_last_addr", last_ma, 18'h067FF);
        chk("E_mem_we_cnt", mem_we_cnt, 512);
        step();

        // Reset in the middle of a write at wr_addr=200
        frame = 1'b1; wr_line = 8'h22; w_seed = '0; wr_req = 1'b1;
        repeat (201) step();
        chk("F_wr_addr_200", wr_addr, 200);
        rst_n = 1'b0;
        #1;
        chk("F_rst_mem_we", mem_we, 0);
        chk("F_rst_busy", busy, 0);
        chk("F_rst_wr_done", wr_done, 0);
        chk("F_rst_wr_addr", wr_addr, 0);
        chk("F_rst_mem_addr", mem_addr, 0);
        chk("F_rst_mem_din", mem_din, 0);
        wr_req = 1'b0;
        m_kind = K_IDLE; m_rdone = 0; m_wdone = 0; pend_we = 0;
        repeat (3) begin
            @(posedge clk);
            #2;
            chk("F_no_wr_done", wr_done, 0);
            chk("F_rst_busy_hold", busy, 0);
        end
        rst_n = 1'b1;
        rd_line = 8'h55; rd_req = 1'b1; clear_stats();
        wait_done(1, k);
        chk("F_rd_we_cnt", rd_we_cnt, 512);
        step();

        // Randomized traffic
        w_seed = 16'($urandom);
        rand_mode = 1;
        repeat (12000) step();
        rand_mode = 0;
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (600) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
